// File: rtl/spi_lb_pkg.sv
// Shared types and constants for the two-requester SPI local-bus arbiter.
package spi_lb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2,
        GAP  = 2'd3
    } state_t;

    localparam int NUM_REQ       = 2;
    localparam int TMO_WIDTH_DEF = 16;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; the pointer remembers the last winner so a
// simultaneous request goes to the other side.
module rr_arb2 (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic [1:0] req,
    input  logic       en,
    output logic [1:0] gnt,
    output logic       idx
);

    logic last;

    always_comb begin
        gnt = 2'b00;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = last ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
        endcase
    end

    assign idx = gnt[1];

    // Reset value 1 makes requester 0 the first winner on contention.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N)
            last <= 1'b1;
        else if (en && (|req))
            last <= idx;
    end

endmodule

// File: rtl/spi_lb_arb.sv
// Round-robin arbiter and transaction sequencer sharing one SPI master
// local-bus port between two requesters, with per-transaction timeout.
module spi_lb_arb
    import spi_lb_pkg::*;
#(
    parameter int P_ADDR_WIDTH = 8,
    parameter int P_DATA_WIDTH = 8,
    parameter int P_TMO_WIDTH  = TMO_WIDTH_DEF
) (
    input  logic                    CLK,
    input  logic                    RST_N,
    input  logic                    REQ0_REQ,
    input  logic                    REQ0_RNW,
    input  logic [P_ADDR_WIDTH-1:0] REQ0_ADR,
    input  logic [P_DATA_WIDTH-1:0] REQ0_WDAT,
    output logic [P_DATA_WIDTH-1:0] REQ0_RDAT,
    output logic                    REQ0_ACK,
    output logic                    REQ0_ERR,
    input  logic                    REQ1_REQ,
    input  logic                    REQ1_RNW,
    input  logic [P_ADDR_WIDTH-1:0] REQ1_ADR,
    input  logic [P_DATA_WIDTH-1:0] REQ1_WDAT,
    output logic [P_DATA_WIDTH-1:0] REQ1_RDAT,
    output logic                    REQ1_ACK,
    output logic                    REQ1_ERR,
    output logic                    M_REQ,
    output logic                    M_RNW,
    output logic [P_ADDR_WIDTH-1:0] M_ADR,
    output logic [P_DATA_WIDTH-1:0] M_WDAT,
    input  logic [P_DATA_WIDTH-1:0] M_RDAT,
    input  logic                    M_ACK,
    output logic                    BUSY,
    output logic                    GNT_ID,
    output logic                    TMO_FLAG,
    input  logic                    TMO_CLR
);

    state_t                                     state, state_nxt;
    logic [NUM_REQ-1:0]                         req_v, rnw_v, gnt, own;
    logic [NUM_REQ-1:0][P_ADDR_WIDTH-1:0]       adr_v;
    logic [NUM_REQ-1:0][P_DATA_WIDTH-1:0]       wdat_v, rdat_q;
    logic [NUM_REQ-1:0]                         ack_q, err_q;
    logic                                       gnt_idx, sel_rnw;
    logic [P_ADDR_WIDTH-1:0]                    sel_adr;
    logic [P_DATA_WIDTH-1:0]                    sel_wdat;
    logic [P_TMO_WIDTH-1:0]                     tmo_cnt;
    logic                                       grant_en, fin_ok, fin_tmo;

    assign req_v  = {REQ1_REQ,  REQ0_REQ};
    assign rnw_v  = {REQ1_RNW,  REQ0_RNW};
    assign adr_v  = {REQ1_ADR,  REQ0_ADR};
    assign wdat_v = {REQ1_WDAT, REQ0_WDAT};

    rr_arb2 u_arb (
        .CLK   (CLK),
        .RST_N (RST_N),
        .req   (req_v),
        .en    (grant_en),
        .gnt   (gnt),
        .idx   (gnt_idx)
    );

    always_comb begin
        sel_rnw  = 1'b0;
        sel_adr  = '0;
        sel_wdat = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt[i]) begin
                sel_rnw  = rnw_v[i];
                sel_adr  = adr_v[i];
                sel_wdat = wdat_v[i];
            end
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (|req_v) state_nxt = WAIT;
            WAIT:    if (M_ACK || (&tmo_cnt)) state_nxt = DONE;
            DONE:    state_nxt = GAP;
            GAP:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // A master ack in the terminal-count cycle takes priority over the timeout.
    always_comb begin
        grant_en = (state == IDLE) && (|req_v);
        fin_ok   = (state == WAIT) && M_ACK;
        fin_tmo  = (state == WAIT) && !M_ACK && (&tmo_cnt);
        BUSY     = (state != IDLE);
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            M_REQ   <= 1'b0;
            M_RNW   <= 1'b0;
            M_ADR   <= '0;
            M_WDAT  <= '0;
            GNT_ID  <= 1'b0;
            tmo_cnt <= '0;
        end else begin
            if (grant_en) begin
                M_REQ   <= 1'b1;
                M_RNW   <= sel_rnw;
                M_ADR   <= sel_adr;
                M_WDAT  <= sel_wdat;
                GNT_ID  <= gnt_idx;
                tmo_cnt <= '0;
            end else if (state == WAIT) begin
                tmo_cnt <= tmo_cnt + 1'b1;
            end
            if (fin_ok || fin_tmo)
                M_REQ <= 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N)
            TMO_FLAG <= 1'b0;
        else if (fin_tmo)
            TMO_FLAG <= 1'b1;
        else if (TMO_CLR)
            TMO_FLAG <= 1'b0;
    end

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++)
            own[i] = (GNT_ID == 1'(i));
    end

    // Read data is only refreshed for the owner, and only on reads or timeouts.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            ack_q  <= '0;
            err_q  <= '0;
            rdat_q <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                ack_q[i] <= (fin_ok || fin_tmo) && own[i];
                err_q[i] <= fin_tmo && own[i];
                if (fin_tmo && own[i])
                    rdat_q[i] <= '1;
                else if (fin_ok && own[i] && M_RNW)
                    rdat_q[i] <= M_RDAT;
            end
        end
    end

    assign REQ0_ACK  = ack_q[0];
    assign REQ1_ACK  = ack_q[1];
    assign REQ0_ERR  = err_q[0];
    assign REQ1_ERR  = err_q[1];
    assign REQ0_RDAT = rdat_q[0];
    assign REQ1_RDAT = rdat_q[1];

endmodule

// File: tb/tb_spi_lb_arb.sv
// Scoreboard bench for spi_lb_arb: a long-timeout instance for normal traffic
// and a 4-bit-timeout instance for the timeout boundary cases.
module tb_spi_lb_arb;

    logic CLK = 1'b0;
    logic RST_N;
    always #5 CLK = ~CLK;

    logic       r0_req, r0_rnw, r1_req, r1_rnw;
    logic [7:0] r0_adr, r0_wdat, r1_adr, r1_wdat;
    logic [7:0] r0_rdat, r1_rdat;
    logic       r0_ack, r0_err, r1_ack, r1_err;
    logic       m_req, m_rnw, m_ack, busy, gnt_id, tmo_flag, tmo_clr;
    logic [7:0] m_adr, m_wdat, m_rdat;

    logic       t_req, t_rnw, t_mack, t_clr;
    logic [7:0] t_adr, t_wdat, t_mrdat;
    logic [7:0] t_rdat0, t_rdat1, t_madr, t_mwdat;
    logic       t_ack0, t_err0, t_ack1, t_err1;
    logic       t_mreq, t_mrnw, t_busy, t_gnt, t_flag;

    spi_lb_arb dut (
        .CLK(CLK), .RST_N(RST_N),
        .REQ0_REQ(r0_req), .REQ0_RNW(r0_rnw), .REQ0_ADR(r0_adr), .REQ0_WDAT(r0_wdat),
        .REQ0_RDAT(r0_rdat), .REQ0_ACK(r0_ack), .REQ0_ERR(r0_err),
        .REQ1_REQ(r1_req), .REQ1_RNW(r1_rnw), .REQ1_ADR(r1_adr), .REQ1_WDAT(r1_wdat),
        .REQ1_RDAT(r1_rdat), .REQ1_ACK(r1_ack), .REQ1_ERR(r1_err),
        .M_REQ(m_req), .M_RNW(m_rnw), .M_ADR(m_adr), .M_WDAT(m_wdat),
        .M_RDAT(m_rdat), .M_ACK(m_ack),
        .BUSY(busy), .GNT_ID(gnt_id), .TMO_FLAG(tmo_flag), .TMO_CLR(tmo_clr)
    );

    spi_lb_arb #(.P_TMO_WIDTH(4)) dut_t (
        .CLK(CLK), .RST_N(RST_N),
        .REQ0_REQ(t_req), .REQ0_RNW(t_rnw), .REQ0_ADR(t_adr), .REQ0_WDAT(t_wdat),
        .REQ0_RDAT(t_rdat0), .REQ0_ACK(t_ack0), .REQ0_ERR(t_err0),
        .REQ1_REQ(1'b0), .REQ1_RNW(1'b0), .REQ1_ADR(8'h00), .REQ1_WDAT(8'h00),
        .REQ1_RDAT(t_rdat1), .REQ1_ACK(t_ack1), .REQ1_ERR(t_err1),
        .M_REQ(t_mreq), .M_RNW(t_mrnw), .M_ADR(t_madr), .M_WDAT(t_mwdat),
        .M_RDAT(t_mrdat), .M_ACK(t_mack),
        .BUSY(t_busy), .GNT_ID(t_gnt), .TMO_FLAG(t_flag), .TMO_CLR(t_clr)
    );

    typedef struct {
        logic       id;
        logic       err;
        logic [7:0] rdat;
    } exp_t;

    exp_t       exp_q[$];
    exp_t       e;
    int         vectors = 0;
    int         miscompares = 0;
    logic [7:0] exp_rd0, exp_rd1;
    logic       last_g;

    // Scoreboard: every requester ack on the main instance is matched in order.
    always @(negedge CLK) begin
        if (RST_N === 1'b1 && (r0_ack === 1'b1 || r1_ack === 1'b1)) begin
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL ack_unexpected: got ack0=%b ack1=%b, required no ack", r0_ack, r1_ack);
            end else begin
                e = exp_q.pop_front();
                if ((r0_ack && r1_ack) || r1_ack !== e.id ||
                    (r1_ack ? r1_err : r0_err) !== e.err ||
                    (r1_ack ? r1_rdat : r0_rdat) !== e.rdat) begin
                    miscompares++;
                    $display("FAIL ack_sb: got ack0=%b ack1=%b err=%b rdat=%h, required id=%0d err=%b rdat=%h",
                             r0_ack, r1_ack, r1_ack ? r1_err : r0_err,
                             r1_ack ? r1_rdat : r0_rdat, e.id, e.err, e.rdat);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1);
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic wait_mreq(input bit tsel, output int n);
        n = 0;
        while (((tsel ? t_mreq : m_req) !== 1'b1) && n < 50) begin
            tick();
            n++;
        end
    endtask

    task automatic test_reset();
        RST_N = 1'b0;
        {r0_req, r0_rnw, r0_adr, r0_wdat, r1_req, r1_rnw, r1_adr, r1_wdat} = '0;
        {m_ack, m_rdat, tmo_clr, t_req, t_rnw, t_adr, t_wdat, t_mack, t_mrdat, t_clr} = '0;
        exp_rd0 = 8'h00;
        exp_rd1 = 8'h00;
        last_g  = 1'b1;
        repeat (2) tick();
        vectors++;
        if ({r0_rdat, r0_ack, r0_err, r1_rdat, r1_ack, r1_err, m_req, m_rnw, m_adr, m_wdat,
             busy, gnt_id, tmo_flag} !== 41'h0) begin
            miscompares++;
            $display("FAIL reset_main: got %h, required all zero",
                     {r0_rdat, r0_ack, r0_err, r1_rdat, r1_ack, r1_err, m_req, m_rnw, m_adr,
                      m_wdat, busy, gnt_id, tmo_flag});
        end
        vectors++;
        if ({t_rdat0, t_ack0, t_err0, t_mreq, t_madr, t_busy, t_flag} !== 21'h0) begin
            miscompares++;
            $display("FAIL reset_tmo: got %h, required all zero",
                     {t_rdat0, t_ack0, t_err0, t_mreq, t_madr, t_busy, t_flag});
        end
        RST_N = 1'b1;
        repeat (2) tick();
        vectors++;
        if ({busy, m_req} !== 2'b00) begin
            miscompares++;
            $display("FAIL idle_after_reset: got busy=%b m_req=%b, required 0 0", busy, m_req);
        end
    endtask

    task automatic test_single_write();
        r0_rnw = 1'b0; r0_adr = 8'h12; r0_wdat = 8'hA5; r0_req = 1'b1;
        tick();
        vectors++;
        if ({m_req, m_rnw, m_adr, m_wdat, gnt_id, busy} !== {1'b1, 1'b0, 8'h12, 8'hA5, 1'b0, 1'b1}) begin
            miscompares++;
            $display("FAIL write_fields: got req=%b rnw=%b adr=%h wdat=%h gnt=%b busy=%b, required 1 0 12 a5 0 1",
                     m_req, m_rnw, m_adr, m_wdat, gnt_id, busy);
        end
        repeat (39) tick();
        exp_q.push_back('{1'b0, 1'b0, exp_rd0});
        m_rdat = 8'h77; m_ack = 1'b1;
        tick();
        m_ack = 1'b0;
        vectors++;
        if ({r0_ack, r0_err, r0_rdat, m_req} !== {1'b1, 1'b0, exp_rd0, 1'b0}) begin
            miscompares++;
            $display("FAIL write_ack: got ack=%b err=%b rdat=%h m_req=%b, required 1 0 %h 0",
                     r0_ack, r0_err, r0_rdat, m_req, exp_rd0);
        end
        r0_req = 1'b0;
        tick();
        vectors++;
        if ({r0_ack, busy, m_req} !== 3'b010) begin
            miscompares++;
            $display("FAIL write_ack_pulse: got ack=%b busy=%b m_req=%b, required 0 1 0", r0_ack, busy, m_req);
        end
        repeat (3) tick();
    endtask

    task automatic test_read();
        r1_rnw = 1'b1; r1_adr = 8'h3C; r1_wdat = 8'h00; r1_req = 1'b1;
        tick();
        vectors++;
        if ({m_req, m_rnw, m_adr, gnt_id} !== {1'b1, 1'b1, 8'h3C, 1'b1}) begin
            miscompares++;
            $display("FAIL read_fields: got req=%b rnw=%b adr=%h gnt=%b, required 1 1 3c 1",
                     m_req, m_rnw, m_adr, gnt_id);
        end
        last_g = 1'b1;
        repeat (5) tick();
        exp_rd1 = 8'h5E;
        exp_q.push_back('{1'b1, 1'b0, exp_rd1});
        m_rdat = 8'h5E; m_ack = 1'b1;
        tick();
        m_ack = 1'b0; m_rdat = 8'h00;
        vectors++;
        if ({r1_ack, r1_err, r1_rdat, r0_ack} !== {1'b1, 1'b0, 8'h5E, 1'b0}) begin
            miscompares++;
            $display("FAIL read_ack: got ack1=%b err=%b rdat=%h ack0=%b, required 1 0 5e 0",
                     r1_ack, r1_err, r1_rdat, r0_ack);
        end
        r1_req = 1'b0;
        repeat (4) tick();
    endtask

    task automatic test_contention();
        int   n;
        int   n0 = 0;
        int   n1 = 0;
        logic eg;
        logic [7:0] rd;
        r0_rnw = 1'b0; r0_adr = 8'h20; r0_wdat = 8'hC0;
        r1_rnw = 1'b1; r1_adr = 8'h21;
        r0_req = 1'b1; r1_req = 1'b1;
        for (int t = 0; t < 8; t++) begin
            eg = (r0_req && r1_req) ? !last_g : r1_req;
            wait_mreq(1'b0, n);
            vectors++;
            if ({gnt_id, m_adr, m_rnw} !== {eg, (eg ? 8'h21 : 8'h20), eg} || n >= 50) begin
                miscompares++;
                $display("FAIL contention_grant%0d: got gnt=%b adr=%h rnw=%b, required %b %h %b",
                         t, gnt_id, m_adr, m_rnw, eg, (eg ? 8'h21 : 8'h20), eg);
            end
            if (t > 0) begin
                vectors++;
                if (n < 3) begin
                    miscompares++;
                    $display("FAIL contention_gap%0d: got %0d low cycles, required at least 3", t, n);
                end
            end
            last_g = eg;
            repeat (3) tick();
            rd = 8'h60 + 8'(t);
            if (eg) exp_rd1 = rd;
            exp_q.push_back('{eg, 1'b0, (eg ? exp_rd1 : exp_rd0)});
            m_rdat = rd; m_ack = 1'b1;
            tick();
            m_ack = 1'b0;
            if (eg) n1++; else n0++;
            if (n0 == 4) r0_req = 1'b0;
            if (n1 == 4) r1_req = 1'b0;
        end
        repeat (4) tick();
        vectors++;
        if (busy !== 1'b0 || r1_rdat !== exp_rd1) begin
            miscompares++;
            $display("FAIL contention_end: got busy=%b rdat1=%h, required 0 %h", busy, r1_rdat, exp_rd1);
        end
    endtask

    task automatic test_timeout();
        int n;
        int c = 0;
        t_rnw = 1'b1; t_adr = 8'h55; t_req = 1'b1;
        wait_mreq(1'b1, n);
        while (t_ack0 !== 1'b1 && c < 40) begin
            tick();
            c++;
        end
        vectors++;
        if (c != 16 || {t_err0, t_rdat0, t_flag, t_mreq} !== {1'b1, 8'hFF, 1'b1, 1'b0}) begin
            miscompares++;
            $display("FAIL tmo_ack: got cycles=%0d err=%b rdat=%h flag=%b m_req=%b, required 16 1 ff 1 0",
                     c, t_err0, t_rdat0, t_flag, t_mreq);
        end
        t_req = 1'b0;
        t_mrdat = 8'h11; t_mack = 1'b1;
        tick();
        t_mack = 1'b0;
        vectors++;
        if ({t_ack0, t_rdat0, t_flag} !== {1'b0, 8'hFF, 1'b1}) begin
            miscompares++;
            $display("FAIL tmo_late_ack: got ack=%b rdat=%h flag=%b, required 0 ff 1", t_ack0, t_rdat0, t_flag);
        end
        repeat (3) tick();
        t_clr = 1'b1;
        tick();
        t_clr = 1'b0;
        vectors++;
        if ({t_flag, t_busy, t_ack0} !== 3'b000) begin
            miscompares++;
            $display("FAIL tmo_clr: got flag=%b busy=%b ack=%b, required 0 0 0", t_flag, t_busy, t_ack0);
        end
    endtask

    task automatic test_ack_at_tc();
        int n;
        t_rnw = 1'b1; t_adr = 8'h66; t_req = 1'b1;
        wait_mreq(1'b1, n);
        repeat (15) tick();
        t_mrdat = 8'h3A; t_mack = 1'b1;
        tick();
        t_mack = 1'b0;
        vectors++;
        if ({t_ack0, t_err0, t_rdat0, t_flag} !== {1'b1, 1'b0, 8'h3A, 1'b0}) begin
            miscompares++;
            $display("FAIL ack_at_tc: got ack=%b err=%b rdat=%h flag=%b, required 1 0 3a 0",
                     t_ack0, t_err0, t_rdat0, t_flag);
        end
        t_req = 1'b0;
        repeat (4) tick();
    endtask

    task automatic test_reset_mid();
        r0_rnw = 1'b0; r0_adr = 8'h44; r0_wdat = 8'h0F; r0_req = 1'b1;
        tick();
        vectors++;
        if ({m_req, gnt_id} !== 2'b10) begin
            miscompares++;
            $display("FAIL rst_mid_grant: got m_req=%b gnt=%b, required 1 0", m_req, gnt_id);
        end
        repeat (3) tick();
        #3;
        RST_N = 1'b0;
        #1;
        vectors++;
        if ({r0_rdat, r0_ack, r0_err, r1_rdat, r1_ack, r1_err, m_req, m_rnw, m_adr, m_wdat,
             busy, gnt_id, tmo_flag} !== 41'h0) begin
            miscompares++;
            $display("FAIL rst_mid_async: got %h, required all zero",
                     {r0_rdat, r0_ack, r0_err, r1_rdat, r1_ack, r1_err, m_req, m_rnw, m_adr,
                      m_wdat, busy, gnt_id, tmo_flag});
        end
        r0_req = 1'b0;
        tick();
        RST_N = 1'b1;
        exp_rd0 = 8'h00; exp_rd1 = 8'h00; last_g = 1'b1;
        tick();
        r0_req = 1'b1; r1_req = 1'b1;
        tick();
        vectors++;
        if ({m_req, gnt_id, m_adr} !== {1'b1, 1'b0, 8'h44}) begin
            miscompares++;
            $display("FAIL rst_mid_rr: got m_req=%b gnt=%b adr=%h, required 1 0 44", m_req, gnt_id, m_adr);
        end
        repeat (2) tick();
        exp_q.push_back('{1'b0, 1'b0, exp_rd0});
        m_rdat = 8'h99; m_ack = 1'b1;
        tick();
        m_ack = 1'b0;
        r0_req = 1'b0; r1_req = 1'b0;
        repeat (5) tick();
        vectors++;
        if (busy !== 1'b0 || exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL rst_mid_end: got busy=%b pending=%0d, required 0 0", busy, exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_read();
        test_contention();
        test_timeout();
        test_ack_at_tc();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
